// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    // Hex legend of the SLP120A16 4x4 pad for a raw index row*4 + col.
    function automatic logic [3:0] keymap_4x4(input logic [3:0] idx);
        logic [3:0] legend;
        legend = '0;
        case (idx)
            4'd0:  legend = 4'h1;
            4'd1:  legend = 4'h2;
            4'd2:  legend = 4'h3;
            4'd3:  legend = 4'hC;
            4'd4:  legend = 4'h4;
            4'd5:  legend = 4'h5;
            4'd6:  legend = 4'h6;
            4'd7:  legend = 4'hD;
            4'd8:  legend = 4'h7;
            4'd9:  legend = 4'h8;
            4'd10: legend = 4'h9;
            4'd11: legend = 4'hE;
            4'd12: legend = 4'hA;
            4'd13: legend = 4'h0;
            4'd14: legend = 4'hB;
            4'd15: legend = 4'hF;
            default: legend = '0;
        endcase
        return legend;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad front end with press/release debounce and
// single-key lockout; reports each accepted key as row*N_COLS + col.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_ROWS-1:0]                 rows,
    output logic [N_COLS-1:0]                 cols,
    output logic [$clog2(N_ROWS*N_COLS)-1:0]  key_code,
    output logic                              key_valid,
    output logic                              key_held
);

    localparam int KW = $clog2(N_ROWS*N_COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES+1);
    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV-1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES-1);
    localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS-1);

    scan_state_t       state, state_n;
    logic [N_ROWS-1:0] rows_s;
    logic [N_COLS-1:0] cols_n, cols_rot;
    logic [CW-1:0]     col_idx, col_idx_n, col_next;
    logic [RW-1:0]     row_idx, row_idx_n, hit_idx;
    logic [DW-1:0]     dwell, dwell_n;
    logic [BW-1:0]     db, db_n;
    logic [KW-1:0]     key_code_n;
    logic              key_valid_n, key_held_n;
    logic [3:0]        hit_count;
    logic [N_ROWS-1:0] row_mask;

    sync_2ff #(.WIDTH(N_ROWS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    // Count set rows and locate the lone set bit for single-key detection.
    always_comb begin
        hit_count = '0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            if (rows_s[i]) begin
                hit_count = hit_count + 4'd1;
                hit_idx   = RW'(i);
            end
        end
    end

    // Column rotation, wrap N_COLS-1 -> 0, and the captured row as a mask.
    always_comb begin
        cols_rot = {cols[N_COLS-2:0], cols[N_COLS-1]};
        col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
        row_mask = N_ROWS'(1) << row_idx;
    end

    // Next-state and next-output logic for the scan/debounce FSM.
    always_comb begin
        state_n     = state;
        cols_n      = cols;
        col_idx_n   = col_idx;
        row_idx_n   = row_idx;
        dwell_n     = dwell;
        db_n        = db;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (hit_count == 4'd1) begin
                        state_n   = PRESS_DB;
                        row_idx_n = hit_idx;
                        db_n      = '0;
                    end else begin
                        cols_n    = cols_rot;
                        col_idx_n = col_next;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            PRESS_DB: begin
                if (rows_s == row_mask) begin
                    if (db == DB_LAST) begin
                        state_n     = HELD;
                        key_code_n  = KW'(int'(row_idx) * N_COLS + int'(col_idx));
                        key_valid_n = 1'b1;
                        key_held_n  = 1'b1;
                    end else begin
                        db_n = db + 1'b1;
                    end
                end else begin
                    state_n   = SCAN;
                    cols_n    = cols_rot;
                    col_idx_n = col_next;
                    dwell_n   = '0;
                end
            end
            HELD: begin
                if (rows_s == '0) begin
                    state_n = RELEASE_DB;
                    db_n    = '0;
                end
            end
            RELEASE_DB: begin
                if (rows_s == '0) begin
                    if (db == DB_LAST) begin
                        state_n    = SCAN;
                        key_held_n = 1'b0;
                        cols_n     = cols_rot;
                        col_idx_n  = col_next;
                        dwell_n    = '0;
                    end else begin
                        db_n = db + 1'b1;
                    end
                end else begin
                    state_n = HELD;
                end
            end
        endcase
    end

    // State, counters, column drive and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            cols      <= N_COLS'(1);
            col_idx   <= '0;
            row_idx   <= '0;
            dwell     <= '0;
            db        <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cols      <= cols_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            dwell     <= dwell_n;
            db        <= db_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a cycle-level behavioural model.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows = '0;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    keypad_scanner #(
        .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    logic chk_en = 1'b0;

    logic [15:0] pressed = '0;   // bit r*4+c = key (r,c) physically down
    logic        drop    = 1'b0; // force all row lines low (contact bounce)

    // Model: phase 0 scanning, 1 confirming press, 2 key down, 3 confirming release.
    int         m_state = 0;
    int         m_col = 0, m_row = 0, m_t = 0, m_db = 0;
    int         m_code = 0;
    logic       m_valid = 1'b0, m_held = 1'b0;
    logic [3:0] m_s1 = '0, m_s2 = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model, advanced on every active edge from the pins alone.
    always @(posedge clk) begin
        logic [3:0] rs;
        if (reset) begin
            m_state = 0; m_col = 0; m_row = 0; m_t = 0; m_db = 0;
            m_code = 0; m_valid = 1'b0; m_held = 1'b0; m_s1 = '0; m_s2 = '0;
        end else begin
            rs = m_s2;
            m_valid = 1'b0;
            case (m_state)
                0: begin
                    if (m_t == SD-1) begin
                        m_t = 0;
                        if ($countones(rs) == 1) begin
                            for (int i = 0; i < NR; i++) if (rs[i]) m_row = i;
                            m_state = 1; m_db = 0;
                        end else m_col = (m_col + 1) % NC;
                    end else m_t++;
                end
                1: begin
                    if (rs == 4'(1 << m_row)) begin
                        if (m_db == DB-1) begin
                            m_state = 2; m_code = m_row*NC + m_col;
                            m_valid = 1'b1; m_held = 1'b1;
                        end else m_db++;
                    end else begin
                        m_state = 0; m_col = (m_col + 1) % NC; m_t = 0;
                    end
                end
                2: if (rs == 0) begin m_state = 3; m_db = 0; end
                default: begin
                    if (rs == 0) begin
                        if (m_db == DB-1) begin
                            m_state = 0; m_held = 1'b0; m_col = (m_col + 1) % NC; m_t = 0;
                        end else m_db++;
                    end else m_state = 2;
                end
            endcase
            m_s2 = m_s1;
            m_s1 = rows;
        end
    end

    // Every-cycle comparison of the DUT pins against the model.
    always @(negedge clk) begin
        if (key_valid === 1'b1) vcnt++;
        if (chk_en) begin
            check("cols", 32'(cols), 32'(1 << m_col));
            check("key_code", 32'(key_code), 32'(m_code));
            check("key_valid", 32'(key_valid), 32'(m_valid));
            check("key_held", 32'(key_held), 32'(m_held));
        end
    end

    // Drive the row lines from the switch matrix, then advance one cycle.
    task automatic step();
        logic [3:0] r;
        r = '0;
        for (int ri = 0; ri < NR; ri++) r[ri] = |(pressed[ri*4 +: 4] & cols);
        rows = drop ? 4'b0 : r;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic wait_state(input int s, input string what);
        int n;
        n = 0;
        while (m_state != s && n < 500) begin step(); n++; end
        total++;
        if (m_state != s) begin
            bad++;
            $display("FAIL %s: timeout, model phase %0d want %0d", what, m_state, s);
        end
    endtask

    task automatic first_valid(output int idx);
        idx = -1;
        for (int i = 0; i < 200; i++) begin
            if (key_valid === 1'b1) begin idx = i; break; end
            step();
        end
    endtask

    initial begin
        int idx, v0;

        // Reset state and column stepping every SCAN_DIV cycles.
        do_reset(2);
        chk_en = 1'b1;
        check("rst_cols", 32'(cols), 32'h1);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        for (int i = 0; i < 20; i++) begin
            check("scan_step", 32'(cols), 32'(1 << ((i / 4) % 4)));
            step();
        end

        // Clean press of (2,1): valid 16 cycles after reset, code 9 = legend 8.
        do_reset(2);
        pressed = 16'h0200;
        first_valid(idx);
        check("press_latency", 32'(idx), 32'd16);
        check("press_code", 32'(key_code), 32'd9);
        check("press_held", 32'(key_held), 32'h1);
        check("legend9", 32'(keymap_4x4(key_code)), 32'h8);
        for (int i = 0; i < 20; i++) step();
        check("held_hold", 32'(key_held), 32'h1);
        pressed = '0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 10) check("held_before_rel", 32'(key_held), 32'h1);
            if (k == 11) check("held_after_rel", 32'(key_held), 32'h0);
        end
        check("code_kept", 32'(key_code), 32'd9);

        // Bounce during press debounce: no pulse, scan resumes at column 2.
        do_reset(2);
        v0 = vcnt;
        pressed = 16'h0200;
        begin
            int n;
            n = 0;
            while (!(m_state == 1 && m_db == 3) && n < 200) begin step(); n++; end
        end
        drop = 1'b1;
        step();
        drop = 1'b0;
        wait_state(0, "bounce_to_scan");
        check("bounce_cols", 32'(cols), 32'h4);
        pressed = '0;
        for (int i = 0; i < 40; i++) step();
        check("bounce_novalid", 32'(vcnt - v0), 32'd0);

        // Extra keys while (0,0) is held: no second pulse, held persists.
        do_reset(2);
        v0 = vcnt;
        pressed = 16'h0001;
        wait_state(2, "held00");
        check("held00_code", 32'(key_code), 32'd0);
        pressed = 16'h9001;
        for (int i = 0; i < 30; i++) step();
        check("rollover_novalid", 32'(vcnt - v0), 32'd1);
        pressed = 16'h9000;
        for (int i = 0; i < 30; i++) step();
        check("held_other_row", 32'(key_held), 32'h1);
        check("rollover_novalid2", 32'(vcnt - v0), 32'd1);
        pressed = '0;
        wait_state(0, "all_released");
        check("released_held", 32'(key_held), 32'h0);

        // Ghost: two rows on column 2 are never accepted.
        do_reset(2);
        v0 = vcnt;
        pressed = 16'h0044;
        for (int i = 0; i < 60; i++) step();
        check("ghost_novalid", 32'(vcnt - v0), 32'd0);
        check("ghost_held", 32'(key_held), 32'h0);
        pressed = '0;

        // Reset while HELD with the key still down, then re-detection.
        do_reset(2);
        pressed = 16'h0200;
        wait_state(2, "held21");
        for (int i = 0; i < 5; i++) step();
        do_reset(1);
        check("midrst_cols", 32'(cols), 32'h1);
        check("midrst_code", 32'(key_code), 32'h0);
        check("midrst_valid", 32'(key_valid), 32'h0);
        check("midrst_held", 32'(key_held), 32'h0);
        first_valid(idx);
        check("redetect_latency", 32'(idx), 32'd16);
        check("redetect_code", 32'(key_code), 32'd9);
        pressed = '0;
        for (int i = 0; i < 20; i++) step();

        check("legend0", 32'(keymap_4x4(4'd0)), 32'h1);
        check("legend13", 32'(keymap_4x4(4'd13)), 32'h0);
        check("legend15", 32'(keymap_4x4(4'd15)), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
